// File: rtl/div_pkg.sv
// Shared definitions for the RV64M divide unit controller.
// Holds the op code encodings, the controller state enum, the default
// operand/op widths, the W-op iteration count and a 32->64 sign-extend helper.
package div_pkg;

   localparam int DIV_XLEN   = 64;
   localparam int DIV_OPW    = 4;
   localparam int DIV_W_ITER = 32;

   localparam logic [DIV_OPW-1:0] DIV_OP_DIV   = 4'd0;
   localparam logic [DIV_OPW-1:0] DIV_OP_REM   = 4'd1;
   localparam logic [DIV_OPW-1:0] DIV_OP_DIVU  = 4'd2;
   localparam logic [DIV_OPW-1:0] DIV_OP_REMU  = 4'd3;
   localparam logic [DIV_OPW-1:0] DIV_OP_DIVW  = 4'd4;
   localparam logic [DIV_OPW-1:0] DIV_OP_REMW  = 4'd5;
   localparam logic [DIV_OPW-1:0] DIV_OP_DIVUW = 4'd6;
   localparam logic [DIV_OPW-1:0] DIV_OP_REMUW = 4'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   function automatic logic [DIV_XLEN-1:0] sext32(input logic [31:0] v);
      return {{(DIV_XLEN-32){v[31]}}, v};
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration, purely combinational.
// Ports:
//   rem      - current partial remainder (always < dsr)
//   dvd_bit  - next dividend bit, MSB first
//   dsr      - divisor magnitude
//   rem_next - partial remainder after the trial subtract
//   q_bit    - quotient bit produced by this step
module div_step
   import div_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
) (
   input  logic [XLEN-1:0] rem,
   input  logic            dvd_bit,
   input  logic [XLEN-1:0] dsr,
   output logic [XLEN-1:0] rem_next,
   output logic            q_bit
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // Since rem < dsr, the shifted value is below 2*dsr, so the difference
   // always fits an XLEN+1 bit two's complement value and its MSB is the sign.
   assign shifted  = {rem, dvd_bit};
   assign diff     = shifted - {1'b0, dsr};
   assign q_bit    = ~diff[XLEN];
   assign rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle RV64M divide/remainder controller, one quotient bit per cycle.
// Optional feature: define DIV_PERF_CNT_EN to add the busy_cycles counter.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   flush                - squash any in-flight or pending operation
//   in_valid/in_ready    - request handshake; src1 dividend, src2 divisor, op
//   out_valid/out_ready  - result handshake; result quotient or remainder
//   busy_cycles          - (DIV_PERF_CNT_EN only) cycles spent in CALC, wraps
//
// state | meaning
// IDLE  | ready for a request
// CALC  | restoring iterations, cnt counts N-1 down to 0
// DONE  | result held until out_ready
module div_ctrl
   import div_pkg::*;
#(
   parameter int XLEN = DIV_XLEN,
   parameter int OPW  = DIV_OPW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic [OPW-1:0]  op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
`ifdef DIV_PERF_CNT_EN
   ,
   output logic [31:0]     busy_cycles
`endif
);

   localparam int CW = $clog2(XLEN);

   div_state_t      state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] dvd;       // dividend bits out of the top, quotient bits into the bottom
   logic [XLEN-1:0] dsr;
   logic [XLEN-1:0] rem;
   logic            q_neg;
   logic            r_neg;
   logic            rem_sel;
   logic            w_sel;

   // request classification
   logic            req_w;
   logic            req_signed;
   logic            req_rem;
   logic            req_bad;
   logic [XLEN-1:0] ext_a;
   logic [XLEN-1:0] ext_b;
   logic [XLEN-1:0] min_neg;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic            div_zero;
   logic            ovf;
   logic [XLEN-1:0] sp_dvd;
   logic [XLEN-1:0] sp_res;
   logic            special;

   always_comb begin
      req_w      = op[2];
      req_signed = ~op[1];
      req_rem    = op[0];
      req_bad    = (op > DIV_OP_REMUW);
      if (req_w) begin
         ext_a   = req_signed ? sext32(src1[31:0]) : {{(XLEN-32){1'b0}}, src1[31:0]};
         ext_b   = req_signed ? sext32(src2[31:0]) : {{(XLEN-32){1'b0}}, src2[31:0]};
         min_neg = sext32(32'h8000_0000);
      end else begin
         ext_a   = src1;
         ext_b   = src2;
         min_neg = {1'b1, {(XLEN-1){1'b0}}};
      end
      a_neg    = req_signed & ext_a[XLEN-1];
      b_neg    = req_signed & ext_b[XLEN-1];
      mag_a    = a_neg ? -ext_a : ext_a;
      mag_b    = b_neg ? -ext_b : ext_b;
      div_zero = (ext_b == '0);
      ovf      = req_signed && (ext_a == min_neg) && (ext_b == '1);
      // W special results are always sign-extended, even for unsigned ops
      sp_dvd   = req_w ? sext32(src1[31:0]) : src1;
      sp_res   = '0;
      if (req_bad)
         sp_res = '0;
      else if (div_zero)
         sp_res = req_rem ? sp_dvd : '1;
      else if (ovf)
         sp_res = req_rem ? '0 : sp_dvd;
      special  = req_bad | div_zero | ovf;
   end

   logic [XLEN-1:0] step_rem;
   logic            step_q;

   div_step #(.XLEN(XLEN)) u_step (
      .rem      (rem),
      .dvd_bit  (dvd[XLEN-1]),
      .dsr      (dsr),
      .rem_next (step_rem),
      .q_bit    (step_q)
   );

   // fix-up of the final iteration's outputs, used only when cnt reaches 0
   logic [XLEN-1:0] q_full;
   logic [XLEN-1:0] q_fix;
   logic [XLEN-1:0] r_fix;
   logic [XLEN-1:0] sel;
   logic [XLEN-1:0] fix_res;

   always_comb begin
      q_full  = {dvd[XLEN-2:0], step_q};
      q_fix   = q_neg ? -q_full : q_full;
      r_fix   = r_neg ? -step_rem : step_rem;
      sel     = rem_sel ? r_fix : q_fix;
      fix_res = w_sel ? sext32(sel[31:0]) : sel;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         cnt       <= '0;
         dvd       <= '0;
         dsr       <= '0;
         rem       <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         rem_sel   <= 1'b0;
         w_sel     <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (special) begin
                     result    <= sp_res;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     // W dividends are left-aligned so the MSB-first feed works unchanged
                     dvd     <= req_w ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
                     dsr     <= mag_b;
                     rem     <= '0;
                     q_neg   <= a_neg ^ b_neg;
                     r_neg   <= a_neg;
                     rem_sel <= req_rem;
                     w_sel   <= req_w;
                     cnt     <= req_w ? CW'(DIV_W_ITER - 1) : CW'(XLEN - 1);
                     state   <= CALC;
                  end
               end
            end
            CALC: begin
               rem <= step_rem;
               dvd <= {dvd[XLEN-2:0], step_q};
               if (cnt == '0) begin
                  result    <= fix_res;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef DIV_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busy_cycles <= '0;
      else if (state == CALC)
         busy_cycles <= busy_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
   import div_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] src1;
   logic [63:0] src2;
   logic [3:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
`ifdef DIV_PERF_CNT_EN
   logic [31:0] busy_cycles;
`endif

   div_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .src1      (src1),
      .src2      (src2),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
`ifdef DIV_PERF_CNT_EN
      ,
      .busy_cycles (busy_cycles)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [63:0] res;
      int          lat;
   } exp_t;

   exp_t sbq[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [63:0] a,
                                           input logic [63:0] b);
      logic [31:0]        a32;
      logic [31:0]        b32;
      logic [31:0]        r32;
      logic signed [31:0] sa32;
      logic signed [31:0] sb32;
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      a32 = a[31:0];
      b32 = b[31:0];
      sa32 = a32;
      sb32 = b32;
      sa = a;
      sb = b;
      r32 = '0;
      case (o)
         4'd0: begin
            if (b == 0) return '1;
            if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
            return sa / sb;
         end
         4'd1: begin
            if (b == 0) return a;
            if (a == 64'h8000_0000_0000_0000 && b == '1) return '0;
            return sa % sb;
         end
         4'd2: return (b == 0) ? '1 : a / b;
         4'd3: return (b == 0) ? a : a % b;
         4'd4: begin
            if (b32 == 0) r32 = '1;
            else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
            else r32 = sa32 / sb32;
         end
         4'd5: begin
            if (b32 == 0) r32 = a32;
            else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
            else r32 = sa32 % sb32;
         end
         4'd6: r32 = (b32 == 0) ? '1 : a32 / b32;
         4'd7: r32 = (b32 == 0) ? a32 : a32 % b32;
         default: return '0;
      endcase
      return {{32{r32[31]}}, r32};
   endfunction

   function automatic int ref_lat(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
      if (o > 4'd7) return 1;
      if (o[2]) begin
         if (b[31:0] == 0) return 1;
         if (!o[1] && a[31:0] == 32'h8000_0000 && b[31:0] == '1) return 1;
         return 33;
      end
      if (b == 0) return 1;
      if (!o[1] && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
      return 65;
   endfunction

   // Issue one request, wait (bounded) for its result, compare against the
   // scoreboard entry, optionally hold out_ready low, then release.
   task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat,
                         input int hold);
      exp_t e;
      int   n;
      logic got;
      sbq.push_back('{tag, exp, lat});
      @(negedge clk);
      op       = o;
      src1     = a;
      src2     = b;
      in_valid = 1'b1;
      n   = 0;
      got = 1'b0;
      while (!got && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         in_valid = 1'b0;
         if (out_valid) got = 1'b1;
      end
      e = sbq.pop_front();
      chk({e.tag, "_seen"}, 64'(got), 64'd1);
      chk({e.tag, "_lat"}, 64'(n), 64'(e.lat));
      chk({e.tag, "_res"}, result, e.res);
      chk({e.tag, "_rdy_done"}, 64'(in_ready), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk({e.tag, "_hold_vld"}, 64'(out_valid), 64'd1);
         chk({e.tag, "_hold_res"}, result, e.res);
         chk({e.tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({e.tag, "_rel_vld"}, 64'(out_valid), 64'd0);
      chk({e.tag, "_rel_rdy"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [3:0]  ro;
      logic [63:0] ra;
      logic [63:0] rb;
`ifdef DIV_PERF_CNT_EN
      logic [31:0] bc0;
`endif
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      src1      = '0;
      src2      = '0;
      op        = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rdy", 64'(in_ready), 64'd1);
      chk("rst_vld", 64'(out_valid), 64'd0);
      chk("rst_res", result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef DIV_PERF_CNT_EN
      chk("perf_rst", 64'(busy_cycles), 64'd0);
      bc0 = busy_cycles;
`endif
      run_op("div_m7_2", DIV_OP_DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
`ifdef DIV_PERF_CNT_EN
      chk("perf_div", 64'(busy_cycles - bc0), 64'd64);
`endif
      run_op("rem_m7_2", DIV_OP_REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
      run_op("divu_100_7", DIV_OP_DIVU, 64'd100, 64'd7, 64'd14, 65, 0);
      run_op("remu_100_7", DIV_OP_REMU, 64'd100, 64'd7, 64'd2, 65, 0);
      run_op("divuw", DIV_OP_DIVUW, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
      run_op("divw_ovf", DIV_OP_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
             64'hFFFF_FFFF_8000_0000, 1, 0);
      run_op("remw_ovf", DIV_OP_REMW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
             64'd0, 1, 0);
      run_op("div_by0", DIV_OP_DIV, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
      run_op("rem_by0", DIV_OP_REM, 64'd5, 64'd0, 64'd5, 1, 0);
      run_op("op_inv", 4'd9, 64'd5, 64'd3, 64'd0, 1, 0);
      run_op("divw_m7_2", DIV_OP_DIVW, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
      run_op("remuw_by0", DIV_OP_REMUW, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1, 0);
      run_op("div_ovf64", DIV_OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0000, 1, 0);
      run_op("hold_divu", DIV_OP_DIVU, 64'd1000, 64'd10, 64'd100, 65, 10);

      for (int i = 0; i < 8; i++) begin
         ro = 4'($urandom_range(0, 7));
         ra = {$urandom, $urandom};
         rb = (i < 4) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
         if (i[0]) ra = -ra;
         run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, ref_res(ro, ra, rb),
                ref_lat(ro, ra, rb), 0);
      end

      // flush in CALC
      @(negedge clk);
      op = DIV_OP_DIVU; src1 = 64'd100; src2 = 64'd7; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 19; i++) begin
         @(posedge clk);
         #1;
         chk("flush_calc_vld", 64'(out_valid), 64'd0);
      end
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_vld", 64'(out_valid), 64'd0);
      chk("flush_rdy", 64'(in_ready), 64'd1);
      for (int i = 0; i < 70; i++) begin
         @(posedge clk);
         #1;
         chk("flush_quiet", 64'(out_valid), 64'd0);
      end
      run_op("after_flush", DIV_OP_DIVU, 64'd9, 64'd3, 64'd3, 65, 0);

      // flush with in_valid in IDLE must not accept
      @(negedge clk);
      op = 4'd9; src1 = 64'd1; src2 = 64'd1; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush = 1'b0;
      chk("flush_idle_rdy", 64'(in_ready), 64'd1);
      chk("flush_idle_vld", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("flush_idle_vld2", 64'(out_valid), 64'd0);

      // flush discards a pending DONE result
      @(negedge clk);
      op = DIV_OP_DIV; src1 = 64'd5; src2 = 64'd0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("done_pend_vld", 64'(out_valid), 64'd1);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_done_vld", 64'(out_valid), 64'd0);
      chk("flush_done_rdy", 64'(in_ready), 64'd1);

      // reset mid-CALC
      @(negedge clk);
      op = DIV_OP_DIV; src1 = -64'sd7; src2 = 64'd2; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_rdy", 64'(in_ready), 64'd1);
      chk("rst_mid_vld", 64'(out_valid), 64'd0);
      chk("rst_mid_res", result, 64'd0);
`ifdef DIV_PERF_CNT_EN
      chk("perf_rst_mid", 64'(busy_cycles), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk);
         #1;
         chk("rst_quiet", 64'(out_valid), 64'd0);
      end
      run_op("after_rst", DIV_OP_DIVU, 64'd9, 64'd3, 64'd3, 65, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle RV64M divide unit controller for the NPC execute stage. It accepts one divide/remainder request at a time over a valid/ready handshake and sequences a one-bit-per-cycle restoring divider. It resolves RISC-V special cases, applies sign and word fix-up, and holds the result until the consumer takes it. It replaces single-cycle combinational division on the critical path, and supports flush from the pipeline.

## Interface
- XLEN, 64, operand/result width
- OPW, 4, op code width
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous squash of any in-flight operation
- in_valid  input  1  request valid
- in_ready  output  1  controller can accept a request
- src1  input  XLEN  dividend
- src2  input  XLEN  divisor
- op  input  OPW  0 DIV, 1 REM, 2 DIVU, 3 REMU, 4 DIVW, 5 REMW, 6 DIVUW, 7 REMUW, 8–15 invalid
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- result  output  XLEN  quotient or remainder

## Operation
- States are IDLE, CALC and DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && !flush the controller captures the operands and op.
  - It classifies the request and goes to CALC, or to DONE for special cases.
- **Operand preparation**
  - W ops use src[31:0] only, sign-extended for signed ops and zero-extended for unsigned ops.
  - Signed ops divide magnitudes and record the quotient sign (s1^s2) and the remainder sign (s1).
  - The iteration count N is 64 for full-width ops and 32 for W ops.
- **Special cases** go to DONE directly with the result loaded:
  - Divide by zero: quotient = all ones; remainder = dividend (W: sign-extended src1[31:0]).
  - Signed overflow (most-negative / −1): quotient = dividend (W: sign-extended), remainder = 0.
  - Invalid op: result = 0.
- **CALC**
  - One restoring step per cycle: shift the partial remainder left with the next dividend bit, trial-subtract the divisor, set the quotient bit.
  - A down-counter runs from N−1 to 0.
  - After the final step, sign fix-up is applied: quotient negated if the quotient sign is set, remainder negated if the remainder sign is set.
  - The result register is loaded with quotient or remainder; W results are sign-extended from bit 31, including DIVUW/REMUW.
  - The state then goes to DONE.
- **DONE**
  - out_valid = 1; result is held stable.
  - On out_ready the state returns to IDLE.
  - A new request is not accepted in the same cycle.
- **flush**
  - Highest priority in every state; the next state is IDLE and out_valid drops the following cycle.
  - A result pending in DONE is discarded.
  - flush together with in_valid in IDLE does not accept the request.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, counter 0, all operand registers 0.
- Reset asserted mid-operation aborts immediately and does not produce out_valid.
- Acceptance happens at edge t0.
- Normal ops:
  - CALC occupies cycles t0+1 … t0+N.
  - out_valid first goes high at cycle t0+N+1: latency 65 cycles for full-width ops, 33 for W ops.
- Special and invalid ops: out_valid goes high at t0+1 (latency 1).
- Throughput is at most one op per N+2 cycles, since DONE→IDLE costs one cycle.
- in_ready is a pure function of state; no combinational path runs from in_valid or out_ready to any output.
- In DONE, out_valid and result stay constant while out_ready is low, for any duration.

## Configuration
- DIV_PERF_CNT_EN
  - Defined: adds output busy_cycles (32-bit).
    - It increments once per cycle spent in CALC and wraps at 2^32.
    - It is cleared only by reset; flush does not clear it.
  - Undefined: the port and counter are absent and behaviour is otherwise identical.

## Structure
- The shared package div_pkg holds:
  - op code localparams (DIV_OP_DIV … DIV_OP_REMUW)
  - the state enum (IDLE/CALC/DONE)
  - XLEN/OPW defaults and the W iteration count 32
- Sub-module div_step: a combinational single restoring iteration.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once.
- div_ctrl holds the FSM, counter, operand, sign and result registers, and the fix-up logic.

## Test plan
- DIV src1=−7, src2=2 → result 0xFFFF_FFFF_FFFF_FFFD with out_valid at cycle 65; REM with the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVUW src1=0x0000_0000_FFFF_FFFE, src2=1 → 0xFFFF_FFFF_FFFF_FFFE at latency 33.
- DIVW src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000 at latency 1; REMW with the same operands → 0.
- DIV 5/0 → 0xFFFF_FFFF_FFFF_FFFF; REM 5/0 → 5; op=9 → 0; all at latency 1.
- Hold out_ready low for 10 cycles in DONE → out_valid and result stable and in_ready 0; on out_ready, IDLE the next cycle.
- flush at CALC step 20 → no out_valid and in_ready=1 the next cycle, and a following DIVU 9/3 returns 3. Repeat with rst_n pulsed low mid-CALC → all outputs at reset values.
